mem_io_bridge: RTL

Memory and I/O subsystem driven directly by the processor's ADDR/DOUT/W outputs; it returns read data on the processor's DIN. It contains a synchronous word RAM plus memory-mapped LEDR, HEX, switch and interval-timer registers. All reads have a uniform 1-cycle latency, matching the processor's fetch/ld wait cycle.

---
 rtl/mem_io_bridge_if.sv | 15 +
 rtl/mem_io_bridge.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_bridge_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_io_bridge_if : processor-side memory bus (ADDR/DOUT/W out, DIN in)   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface mem_io_bridge_if;
   logic [15:0] addr;
   logic [15:0] dout;
   logic        w;
   logic [15:0] din;

   modport master (output addr, output dout, output w, input din);
   modport slave  (input addr, input dout, input w, output din);
endinterface
`default_nettype wire

// File: rtl/mem_io_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_io_bridge : word RAM plus LEDR/HEX/SW/timer registers, 1-cycle reads  |
// | Optional timer region 0x4xxx enabled by macro MEMIO_TIMER_EN.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_io_bridge #(
   parameter int RAM_AW = 8,
   parameter int LED_W  = 10,
   parameter int SW_W   = 10,
   parameter int TMR_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   mem_io_bridge_if.slave    bus,
   input  logic [SW_W-1:0]   sw,
   output logic [LED_W-1:0]  ledr,
   output logic [6:0]        hex0,
   output logic [6:0]        hex1,
   output logic [6:0]        hex2,
   output logic [6:0]        hex3,
   output logic [6:0]        hex4,
   output logic [6:0]        hex5,
   output logic              tmr_irq
);
   localparam logic [3:0] REG_RAM = 4'h0;
   localparam logic [3:0] REG_LED = 4'h1;
   localparam logic [3:0] REG_HEX = 4'h2;
   localparam logic [3:0] REG_SW  = 4'h3;
   localparam logic [3:0] REG_TMR = 4'h4;

   typedef enum logic [1:0] {SEL_NONE, SEL_RAM, SEL_PER} rd_sel_t;

   logic [3:0]       region;
   logic             hex_hit;
   logic             wr_ram;
   logic [15:0]      ram [0:(1<<RAM_AW)-1];
   logic [15:0]      ram_q;
   logic [15:0]      per_rd;
   logic [15:0]      per_q;
   logic [15:0]      tmr_rd;
   rd_sel_t          rd_sel;
   rd_sel_t          rd_sel_nxt;
   logic [6:0]       hex_r [6];
   logic [SW_W-1:0]  sw_s1;
   logic [SW_W-1:0]  sw_s2;

   assign region  = bus.addr[15:12];
   assign hex_hit = bus.addr[11:0] < 12'd6;
   // Gating with rst drops a RAM write whose edge lands while reset is held.
   assign wr_ram  = bus.w && (region == REG_RAM) && !rst;

   always_ff @(posedge clk) begin
      if (wr_ram) begin
         ram[bus.addr[RAM_AW-1:0]] <= bus.dout;
      end
      ram_q <= ram[bus.addr[RAM_AW-1:0]];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ledr  <= '0;
         sw_s1 <= '0;
         sw_s2 <= '0;
         for (int i = 0; i < 6; i++) begin
            hex_r[i] <= 7'h7F;
         end
      end else begin
         sw_s1 <= sw;
         sw_s2 <= sw_s1;
         if (bus.w && region == REG_LED) begin
            ledr <= bus.dout[LED_W-1:0];
         end
         for (int i = 0; i < 6; i++) begin
            if (bus.w && region == REG_HEX && hex_hit && bus.addr[2:0] == 3'(i)) begin
               hex_r[i] <= bus.dout[6:0];
            end
         end
      end
   end

   assign hex0 = hex_r[0];
   assign hex1 = hex_r[1];
   assign hex2 = hex_r[2];
   assign hex3 = hex_r[3];
   assign hex4 = hex_r[4];
   assign hex5 = hex_r[5];

`ifdef MEMIO_TIMER_EN
   logic             tmr_en;
   logic             tmr_auto;
   logic             tmr_to;
   logic [TMR_W-1:0] tmr_load;
   logic [TMR_W-1:0] tmr_count;
   logic             wr_tmr;
   logic             tmr_timeout;

   assign wr_tmr      = bus.w && (region == REG_TMR);
   assign tmr_timeout = tmr_en && (tmr_count == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmr_en    <= 1'b0;
         tmr_auto  <= 1'b0;
         tmr_to    <= 1'b0;
         tmr_load  <= '0;
         tmr_count <= '0;
      end else begin
         if (tmr_timeout) begin
            tmr_to <= 1'b1;
            if (!tmr_auto) begin
               tmr_en <= 1'b0;
            end
         end else if (wr_tmr && bus.addr[1:0] == 2'd3) begin
            tmr_to <= 1'b0;
         end

         if (wr_tmr && bus.addr[1:0] == 2'd1) begin
            tmr_load  <= bus.dout[TMR_W-1:0];
            tmr_count <= bus.dout[TMR_W-1:0];
         end else if (tmr_timeout) begin
            if (tmr_auto) begin
               tmr_count <= tmr_load;
            end
         end else if (tmr_en) begin
            tmr_count <= tmr_count - TMR_W'(1);
         end

         // A CTRL write overrides the auto-stop of a coinciding one-shot timeout.
         if (wr_tmr && bus.addr[1:0] == 2'd0) begin
            tmr_en   <= bus.dout[0];
            tmr_auto <= bus.dout[1];
         end
      end
   end

   always_comb begin
      tmr_rd = '0;
      case (bus.addr[1:0])
         2'd0:    tmr_rd[1:0]       = {tmr_auto, tmr_en};
         2'd1:    tmr_rd[TMR_W-1:0] = tmr_load;
         2'd2:    tmr_rd[TMR_W-1:0] = tmr_count;
         default: tmr_rd[0]         = tmr_to;
      endcase
   end

   assign tmr_irq = tmr_to;
`else
   assign tmr_rd  = '0;
   assign tmr_irq = 1'b0;
`endif

   always_comb begin
      per_rd     = '0;
      rd_sel_nxt = SEL_NONE;
      case (region)
         REG_RAM: rd_sel_nxt = SEL_RAM;
         REG_LED: begin
            rd_sel_nxt         = SEL_PER;
            per_rd[LED_W-1:0]  = ledr;
         end
         REG_HEX: begin
            rd_sel_nxt = SEL_PER;
            for (int i = 0; i < 6; i++) begin
               if (hex_hit && bus.addr[2:0] == 3'(i)) begin
                  per_rd[6:0] = hex_r[i];
               end
            end
         end
         REG_SW: begin
            rd_sel_nxt        = SEL_PER;
            per_rd[SW_W-1:0]  = sw_s2;
         end
         REG_TMR: begin
            rd_sel_nxt = SEL_PER;
            per_rd     = tmr_rd;
         end
         default: rd_sel_nxt = SEL_NONE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_sel <= SEL_NONE;
         per_q  <= '0;
      end else begin
         rd_sel <= rd_sel_nxt;
         per_q  <= per_rd;
      end
   end

   always_comb begin
      case (rd_sel)
         SEL_RAM: bus.din = ram_q;
         SEL_PER: bus.din = per_q;
         default: bus.din = 16'h0000;
      endcase
   end
endmodule
`default_nettype wire
